// File: rtl/axi_burst_pkg.sv
// Shared encodings and FSM state types for the AXI4 burst memory slave.
package axi_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality check for one AXI channel.
// WRAP bursts are only honoured when AXI_BURST_SLAVE_WRAP_EN is defined.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  localparam int         LANE_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;

  assign step      = ADDR_WIDTH'(1) << size;
  assign incr_addr = addr + step;

`ifdef AXI_BURST_SLAVE_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_len_ok;

  // Boundary is (len+1)<<size bytes; only power-of-two lengths give a clean mask.
  assign wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`endif

  always_comb begin
    next_addr = incr_addr;
    illegal   = (size > MAX_SIZE);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
`ifdef AXI_BURST_SLAVE_WRAP_EN
      BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        illegal   = illegal | ~wrap_len_ok;
      end
`endif
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI4 burst memory slave: independent read/write FSMs over a word-organised RAM.
// Write bursts are staged in a shadow copy and committed only if the whole burst is clean.
module axi_burst_slave
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTE_LANES = DATA_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(BYTE_LANES);
  localparam int WORD_BITS  = ADDR_WIDTH - LANE_BITS;
  localparam int DEPTH      = 1 << WORD_BITS;

  // Holds address-ready low until the first clock after reset release.
  logic ready_en_reg;

  // ---------------- write channel ----------------
  w_state_e              w_state_reg, w_state_next;
  logic [ID_WIDTH-1:0]   w_id_reg;
  logic [ADDR_WIDTH-1:0] w_addr_reg;
  logic [7:0]            w_len_reg;
  logic [7:0]            w_cnt_reg;
  logic [2:0]            w_size_reg;
  logic [1:0]            w_burst_reg;
  logic                  w_err_reg;
  logic [1:0]            b_resp_reg;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_illegal;
  logic                  aw_hs, w_hs, w_beat_last, w_lastbad, w_bad;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign w_beat_last = (w_cnt_reg == w_len_reg);
  assign w_lastbad   = (wlast != w_beat_last);
  assign w_bad       = w_illegal | w_err_reg | w_lastbad;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_addr_gen (
    .addr      (w_addr_reg),
    .len       (w_len_reg),
    .size      (w_size_reg),
    .burst     (w_burst_reg),
    .next_addr (w_addr_nxt),
    .illegal   (w_illegal)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_reg <= 1'b0;
      w_state_reg  <= W_IDLE;
      w_id_reg     <= '0;
      w_addr_reg   <= '0;
      w_len_reg    <= '0;
      w_cnt_reg    <= '0;
      w_size_reg   <= '0;
      w_burst_reg  <= '0;
      w_err_reg    <= 1'b0;
      b_resp_reg   <= RESP_OKAY;
    end else begin
      ready_en_reg <= 1'b1;
      w_state_reg  <= w_state_next;
      if (aw_hs) begin
        w_id_reg    <= awid;
        w_addr_reg  <= awaddr;
        w_len_reg   <= awlen;
        w_size_reg  <= awsize;
        w_burst_reg <= awburst;
        w_cnt_reg   <= '0;
        w_err_reg   <= 1'b0;
      end else if (w_hs) begin
        w_addr_reg <= w_addr_nxt;
        w_cnt_reg  <= w_cnt_reg + 8'd1;
        if (w_lastbad) w_err_reg <= 1'b1;
        if (w_beat_last) b_resp_reg <= w_bad ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        awready = ready_en_reg;
        if (awvalid && ready_en_reg) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_beat_last) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign bid   = w_id_reg;
  assign bresp = b_resp_reg;

  // ---------------- memory ----------------
  logic [DATA_WIDTH-1:0] mem    [DEPTH];
  logic [DATA_WIDTH-1:0] shadow [DEPTH];
  logic [WORD_BITS-1:0]  w_word;
  logic [DATA_WIDTH-1:0] shadow_word, staged_word;
  logic                  stage_we, commit, revert;

  assign w_word      = w_addr_reg[ADDR_WIDTH-1:LANE_BITS];
  assign shadow_word = shadow[w_word];
  assign stage_we    = w_hs & ~w_bad & ~w_beat_last;
  assign commit      = w_hs & w_beat_last & ~w_bad;
  assign revert      = w_hs & w_beat_last & w_bad;

  for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
    assign staged_word[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : shadow_word[gi*8 +: 8];
  end

  // Shadow mirrors mem between bursts; a clean last beat publishes it, a dirty one discards it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (stage_we) shadow[w_word] <= staged_word;
      if (commit) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= shadow[i];
        mem[w_word]    <= staged_word;
        shadow[w_word] <= staged_word;
      end
      if (revert) begin
        for (int i = 0; i < DEPTH; i++) shadow[i] <= mem[i];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_reg, r_state_next;
  logic [ID_WIDTH-1:0]   r_id_reg;
  logic [ADDR_WIDTH-1:0] r_addr_reg;
  logic [7:0]            r_len_reg;
  logic [7:0]            r_cnt_reg;
  logic [2:0]            r_size_reg;
  logic [1:0]            r_burst_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;
  logic                  r_illegal;
  logic                  ar_hs, r_hs, r_beat_last;
  logic [WORD_BITS-1:0]  r_word;

  assign ar_hs       = arvalid & arready;
  assign r_hs        = rvalid & rready;
  assign r_beat_last = (r_cnt_reg == r_len_reg);
  assign r_word      = ar_hs ? araddr[ADDR_WIDTH-1:LANE_BITS] : r_addr_nxt[ADDR_WIDTH-1:LANE_BITS];

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_addr_gen (
    .addr      (r_addr_reg),
    .len       (r_len_reg),
    .size      (r_size_reg),
    .burst     (r_burst_reg),
    .next_addr (r_addr_nxt),
    .illegal   (r_illegal)
  );

  // The beat on the bus is always already fetched, so handshakes can run back to back.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_reg <= R_IDLE;
      r_id_reg    <= '0;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_size_reg  <= '0;
      r_burst_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) begin
        r_id_reg    <= arid;
        r_addr_reg  <= araddr;
        r_len_reg   <= arlen;
        r_size_reg  <= arsize;
        r_burst_reg <= arburst;
        r_cnt_reg   <= '0;
        rdata_reg   <= mem[r_word];
      end else if (r_hs && !r_beat_last) begin
        r_addr_reg <= r_addr_nxt;
        r_cnt_reg  <= r_cnt_reg + 8'd1;
        rdata_reg  <= mem[r_word];
      end
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        arready = ready_en_reg;
        if (arvalid && ready_en_reg) r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && r_beat_last) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign rid   = r_id_reg;
  assign rlast = rvalid & r_beat_last;
  assign rresp = (rvalid && r_illegal) ? RESP_SLVERR : RESP_OKAY;
  assign rdata = (rvalid && !r_illegal) ? rdata_reg : '0;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed self-checking bench for axi_burst_slave (32-bit data, 10-bit address).
module tb_axi_burst_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [9:0]  awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [9:0]  araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wbuf  [16];
  logic [3:0]  sbuf  [16];
  logic [31:0] ebuf  [16];
  logic [31:0] rbuf  [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [3:0]  ridbuf[16];

  axi_burst_slave #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .ID_WIDTH   (4)
  ) dut (
    .aclk    (aclk),    .aresetn (aresetn),
    .awid    (awid),    .awaddr  (awaddr),  .awlen  (awlen),
    .awsize  (awsize),  .awburst (awburst), .awvalid(awvalid), .awready(awready),
    .wdata   (wdata),   .wstrb   (wstrb),   .wlast  (wlast),   .wvalid (wvalid),
    .wready  (wready),
    .bid     (bid),     .bresp   (bresp),   .bvalid (bvalid),  .bready (bready),
    .arid    (arid),    .araddr  (araddr),  .arlen  (arlen),
    .arsize  (arsize),  .arburst (arburst), .arvalid(arvalid), .arready(arready),
    .rid     (rid),     .rdata   (rdata),   .rresp  (rresp),   .rlast  (rlast),
    .rvalid  (rvalid),  .rready  (rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int last_beat,
                          output logic [1:0] resp, output logic [3:0] rsp_id);
    int to;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    to = 0;
    while (!awready && to < 64) begin @(negedge aclk); to++; end
    check_val("awready", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    check_val("wready_latency", 32'(wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == last_beat);
      to = 0;
      while (!wready && to < 64) begin @(negedge aclk); to++; end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_val("bvalid_latency", 32'(bvalid), 32'd1);
    bready = 1'b1;
    to = 0;
    while (!bvalid && to < 64) begin @(negedge aclk); to++; end
    resp = bresp; rsp_id = bid;
    @(negedge aclk);
    bready = 1'b0;
    check_val("awready_after_b", 32'(awready), 32'd1);
    $display("write addr=%h len=%0d burst=%b bresp=%b bid=%h", addr, len, burst, resp, rsp_id);
  endtask

  task automatic do_read(input logic [9:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input bit toggle);
    int to;
    int got;
    bit stalled;
    bit phase;
    logic [31:0] hold_data;
    logic        hold_last;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    to = 0;
    while (!arready && to < 64) begin @(negedge aclk); to++; end
    check_val("arready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check_val("rvalid_latency", 32'(rvalid), 32'd1);
    got = 0; to = 0; stalled = 1'b0; phase = 1'b1;
    hold_data = '0; hold_last = 1'b0;
    while (got <= int'(len) && to < 600) begin
      if (stalled) begin
        check_val("r_stall_data", rdata, hold_data);
        check_val("r_stall_last", 32'(rlast), 32'(hold_last));
      end
      rready = toggle ? phase : 1'b1;
      phase  = ~phase;
      if (rvalid && rready) begin
        rbuf[got] = rdata; rrbuf[got] = rresp; rlbuf[got] = rlast; ridbuf[got] = rid;
        got++;
        stalled = 1'b0;
      end else if (rvalid) begin
        stalled = 1'b1; hold_data = rdata; hold_last = rlast;
      end
      @(negedge aclk);
      to++;
    end
    rready = 1'b0;
    check_val("r_beats", 32'(got), 32'(int'(len) + 1));
    $display("read  addr=%h len=%0d burst=%b beat0=%h rresp0=%b", addr, len, burst, rbuf[0], rrbuf[0]);
  endtask

  task automatic check_burst(input string tag, input int len, input logic [1:0] eresp,
                             input logic [3:0] eid);
    for (int i = 0; i <= len; i++) begin
      check_val($sformatf("%s_data%0d", tag, i), rbuf[i], ebuf[i]);
      check_val($sformatf("%s_resp%0d", tag, i), 32'(rrbuf[i]), 32'(eresp));
      check_val($sformatf("%s_last%0d", tag, i), 32'(rlbuf[i]), 32'(i == len));
    end
    check_val($sformatf("%s_rid", tag), 32'(ridbuf[0]), 32'(eid));
  endtask

  logic [1:0] resp_a;
  logic [3:0] bid_a;

  initial begin
    // reset state
    repeat (3) @(negedge aclk);
    check_val("rst_awready", 32'(awready), 32'd0);
    check_val("rst_arready", 32'(arready), 32'd0);
    check_val("rst_wready",  32'(wready),  32'd0);
    check_val("rst_bvalid",  32'(bvalid),  32'd0);
    check_val("rst_rvalid",  32'(rvalid),  32'd0);
    aresetn = 1'b1;
    #1 check_val("rel_awready_0", 32'(awready), 32'd0);
    @(negedge aclk);
    check_val("rel_awready_1", 32'(awready), 32'd1);
    check_val("rel_arready_1", 32'(arready), 32'd1);

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(10'h010, 8'd3, 3'd2, 2'b01, 4'h5, 3, resp_a, bid_a);
    check_val("incr_bresp", 32'(resp_a), 32'h0);
    check_val("incr_bid",   32'(bid_a),  32'h5);
    do_read(10'h010, 8'd3, 3'd2, 2'b01, 4'h6, 1'b0);
    ebuf[0] = 32'd1; ebuf[1] = 32'd2; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
    check_burst("incr_rd", 3, 2'b00, 4'h6);

    // FIXED read repeats the start word
    do_read(10'h014, 8'd1, 3'd2, 2'b00, 4'h1, 1'b0);
    ebuf[0] = 32'd2; ebuf[1] = 32'd2;
    check_burst("fixed_rd", 1, 2'b00, 4'h1);

    // oversized beat is rejected
    do_read(10'h010, 8'd0, 3'd3, 2'b01, 4'h2, 1'b0);
    ebuf[0] = 32'd0;
    check_burst("size_err", 0, 2'b10, 4'h2);

    // WRAP read across a 16-byte boundary
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(10'h030, 8'd3, 3'd2, 2'b01, 4'h3, 3, resp_a, bid_a);
    check_val("wrapprep_bresp", 32'(resp_a), 32'h0);
    do_read(10'h038, 8'd3, 3'd2, 2'b10, 4'h9, 1'b0);
`ifdef AXI_BURST_SLAVE_WRAP_EN
    ebuf[0] = 32'hA2; ebuf[1] = 32'hA3; ebuf[2] = 32'hA0; ebuf[3] = 32'hA1;
    check_burst("wrap_rd", 3, 2'b00, 4'h9);
`else
    for (int i = 0; i < 4; i++) ebuf[i] = 32'h0;
    check_burst("wrap_rd", 3, 2'b10, 4'h9);
`endif

    // byte strobes on a previously-zero word
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    do_write(10'h040, 8'd0, 3'd2, 2'b01, 4'h4, 0, resp_a, bid_a);
    check_val("strb_bresp", 32'(resp_a), 32'h0);
    do_read(10'h040, 8'd0, 3'd2, 2'b01, 4'h4, 1'b0);
    ebuf[0] = 32'h00BB00DD;
    check_burst("strb_rd", 0, 2'b00, 4'h4);

    // early wlast: burst errors and memory keeps its old contents
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h11 + 32'(i); sbuf[i] = 4'hF; end
    do_write(10'h050, 8'd3, 3'd2, 2'b01, 4'h2, 3, resp_a, bid_a);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hEE00 + 32'(i);
    do_write(10'h050, 8'd3, 3'd2, 2'b01, 4'hC, 1, resp_a, bid_a);
    check_val("early_last_bresp", 32'(resp_a), 32'h2);
    check_val("early_last_bid",   32'(bid_a),  32'hC);
    do_read(10'h050, 8'd3, 3'd2, 2'b01, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) ebuf[i] = 32'h11 + 32'(i);
    check_burst("early_last_rd", 3, 2'b00, 4'h0);

    // concurrent write and stalled read
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(10'h080, 8'd3, 3'd2, 2'b01, 4'h1, 3, resp_a, bid_a);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + 32'(i);
    fork
      do_write(10'h000, 8'd3, 3'd2, 2'b01, 4'hA, 3, resp_a, bid_a);
      do_read(10'h080, 8'd3, 3'd2, 2'b01, 4'hB, 1'b1);
    join
    check_val("conc_bresp", 32'(resp_a), 32'h0);
    for (int i = 0; i < 4; i++) ebuf[i] = 32'hC0 + 32'(i);
    check_burst("conc_rd", 3, 2'b00, 4'hB);
    do_read(10'h000, 8'd3, 3'd2, 2'b01, 4'h3, 1'b0);
    for (int i = 0; i < 4; i++) ebuf[i] = 32'hD0 + 32'(i);
    check_burst("conc_wr_rd", 3, 2'b00, 4'h3);

    // reset during beat 2 of a write
    @(negedge aclk);
    awid = 4'h7; awaddr = 10'h010; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wlast = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check_val("mid_rst_bvalid",  32'(bvalid),  32'd0);
    check_val("mid_rst_awready", 32'(awready), 32'd0);
    check_val("mid_rst_wready",  32'(wready),  32'd0);
    @(negedge aclk);
    wvalid = 1'b0;
    aresetn = 1'b1;
    #1 check_val("mid_rel_awready_0", 32'(awready), 32'd0);
    @(negedge aclk);
    check_val("mid_rel_awready_1", 32'(awready), 32'd1);
    do_read(10'h010, 8'd3, 3'd2, 2'b01, 4'h8, 1'b0);
    for (int i = 0; i < 4; i++) ebuf[i] = 32'h0;
    check_burst("post_rst_rd", 3, 2'b00, 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_slave.md
# axi_burst_slave

Parametrised AXI4 memory slave: a word-organised RAM behind full write-address, write-data, write-response, read-address and read-data channels. It supports FIXED/INCR/WRAP bursts up to 256 beats, narrow transfers, byte strobes, per-transaction IDs and error responses. Read and write paths are independent and may run concurrently. It replaces the single-beat, 8-entry slave as the default memory target in the AXI subsystem.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width.
- DATA_WIDTH, 32, data bus width; must be 32, 64 or 128.
- ID_WIDTH, 4, AXI ID width.
- Memory depth is 2**(ADDR_WIDTH - log2(DATA_WIDTH/8)) words (derived, not a parameter).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- awid, awaddr, awlen, awsize, awburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address payload.
- awvalid  in  1; awready  out  1.
- wdata  in  DATA_WIDTH; wstrb  in  DATA_WIDTH/8; wlast  in  1; wvalid  in  1; wready  out  1.
- bid  out  ID_WIDTH; bresp  out  2; bvalid  out  1; bready  in  1.
- arid, araddr, arlen, arsize, arburst  in  same widths as AW; arvalid  in  1; arready  out  1.
- rid  out  ID_WIDTH; rdata  out  DATA_WIDTH; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.

## Operation
- Reset: all outputs are 0, both FSMs are IDLE, and memory is cleared to 0. awready and arready rise on the first clock after aresetn deasserts.
- Write FSM states are W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready=1. An AW handshake latches the ID, address, length, size and burst, clears the beat counter and the error flag, and moves to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes of wdata into word addr>>log2(DATA_WIDTH/8), then advances the address. On the beat where count==awlen the FSM moves to W_RESP.
  - W_RESP: bvalid=1 with bid equal to the latched awid and bresp OKAY (00) or SLVERR (10). The FSM returns to W_IDLE on bready.
- Read FSM states are R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: arready=1.
  - R_DATA: rvalid=1 and rid equals the latched arid. rlast=1 only on beat arlen. Each R handshake advances the address. The FSM returns to R_IDLE after the last beat is handshaken.
- Address generation:
  - Step is 1<<size.
  - FIXED: the address is constant.
  - INCR: addr+step, taken modulo 2**ADDR_WIDTH.
  - WRAP: the wrap boundary is (len+1)<<size; the address wraps to the start address aligned down to that boundary.
- SLVERR conditions (the burst still completes with the full beat count):
  - size > log2(DATA_WIDTH/8);
  - burst==11;
  - WRAP with len not in {1,3,7,15};
  - on writes, wlast not matching count==awlen on any beat.
- Error handling:
  - An erroring write burst writes no memory for any of its beats.
  - An erroring read burst returns rdata=0 and rresp=SLVERR on every beat.
- Narrow transfers: data sits on the byte lanes selected by the address. The slave does not mask wstrb; the master's lanes are used as-is.
- Read and write to the same word in the same cycle: the read returns the old data (read-before-write).

## Timing
- AW handshake at cycle N → wready=1 at N+1.
- W beats accept one per cycle while wvalid is high, with no bubbles.
- Last W beat at cycle M → bvalid=1 at M+1. bvalid holds until bready. awready=1 the cycle after the B handshake.
- AR handshake at cycle N → rvalid=1 with beat 0 at N+1.
- Read data is prefetched: with rready held high, beats are back-to-back, one per cycle.
- While rvalid=1 and rready=0, rdata, rresp, rlast and rid are held stable.
- Back-to-back bursts on a channel: each new address handshake is accepted no earlier than one cycle after the previous burst completes.
- Reset asserted mid-burst: all FSMs return to IDLE immediately and the burst is abandoned; no response is issued.

## Configuration
- AXI_BURST_SLAVE_WRAP_EN defined: WRAP bursts are supported as described above.
- Not defined: burst==10 is treated like reserved 11. It returns SLVERR and uses INCR addressing. The wrap-boundary logic is not compiled.

## Structure
- Package axi_burst_pkg holds:
  - burst encodings BURST_FIXED=00, BURST_INCR=01, BURST_WRAP=10;
  - response encodings RESP_OKAY=00, RESP_SLVERR=10;
  - the write-FSM and read-FSM state enums.
- Sub-module axi_burst_addr_gen: combinational next-address and burst-legality checker, given addr, len, size and burst. It is instantiated once for the write channel and once for the read channel.

## Test plan
- INCR write: awaddr=0x10, awlen=3, size=2, wdata 1,2,3,4, full strobes → bresp=00. An INCR read of the same burst → rdata 1,2,3,4 with rlast on beat 3.
- WRAP read: araddr=0x38, len=3, size=2, DATA_WIDTH=32 → beats from words at 0x38, 0x3C, 0x30, 0x34. Without the macro → rresp=10 on all 4 beats.
- Strobes: write 0xAABBCCDD with wstrb=0101 to a word previously holding 0 → a read returns 0x00BB00DD.
- Early wlast on beat 1 of a len=3 write → bresp=10, memory unchanged.
- Concurrency with backpressure: a 4-beat write to 0x00 runs simultaneously with a 4-beat read of 0x80, with rready toggling 1,0,1,0 → the read data is correct and stable while stalled, and the write response is OKAY.
- Reset asserted during beat 2 of a write → bvalid=0, awready=0, then awready=1 the first clock after release; memory reads 0.
